bus_mem_responder: RTL and testbench

//  Memory-mapped RAM responder: the target end of the processor system bus (A/D/RW/FI/DT).

---
 rtl/bus_mem_responder_if.sv | 24 ++
 rtl/bus_mem_responder.sv | 121 ++++++++++++
 tb/tb_bus_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// System bus signals as seen by the memory responder (address, data, direction, request/ack).
// The initiator side uses the master modport; the responder uses the slave modport.
interface bus_mem_responder_if;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        rw;
    logic        fi;
    logic        dt;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output a, d_in, rw, fi, dt,
        input  d_out, d_oe, ack, err, busy
    );

    modport slave (
        input  a, d_in, rw, fi, dt,
        output d_out, d_oe, ack, err, busy
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-mapped byte RAM responder on the system bus with programmable wait states.
// Optional BUS_RESP_FETCH_GUARD_EN: instruction fetches complete with ERR and never touch the RAM.
module bus_mem_responder #(
    parameter logic [15:0] BASE        = 16'hC000,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    bus_mem_responder_if.slave bus
);

`ifdef BUS_RESP_FETCH_GUARD_EN
    localparam logic FETCH_GUARD = 1'b1;
`else
    localparam logic FETCH_GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic              rw_q, rw_d;
    logic              fi_q, fi_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        ram_q [2**ADDR_W];

    logic              hit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_off;
    logic [7:0]        wr_data;
    logic              blocked_q;

    assign hit       = (bus.a[15:ADDR_W] == BASE[15:ADDR_W]);
    assign blocked_q = FETCH_GUARD & fi_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        rw_d    = rw_q;
        fi_d    = fi_q;
        wdata_d = wdata_q;
        wr_en   = 1'b0;
        wr_off  = off_q;
        wr_data = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dt && hit) begin
                    off_d   = bus.a[ADDR_W-1:0];
                    rw_d    = bus.rw;
                    fi_d    = bus.fi;
                    wdata_d = bus.d_in;
                    if (WAIT_STATES == 0) begin
                        // Zero-wait writes commit straight from the bus on the capture edge
                        state_d = S_ACK;
                        wr_en   = !bus.rw && !(FETCH_GUARD && bus.fi);
                        wr_off  = bus.a[ADDR_W-1:0];
                        wr_data = bus.d_in;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.dt) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    wr_en   = !rw_q && !blocked_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.dt) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        off_q   <= off_d;
        rw_q    <= rw_d;
        fi_q    <= fi_d;
        wdata_q <= wdata_d;
    end

    // RAM survives reset; a write racing an asserted reset is dropped
    always_ff @(posedge clk_i) begin
        if (wr_en && rst_ni) begin
            ram_q[wr_off] <= wr_data;
        end
    end

    assign bus.ack   = (state_q == S_ACK);
    assign bus.err   = bus.ack & blocked_q;
    assign bus.d_oe  = bus.ack & rw_q & ~blocked_q;
    assign bus.d_out = bus.d_oe ? ram_q[off_q] : 8'h00;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three instances (0, 1 and 3 wait states) share one bus stimulus,
// each checked every cycle against a transaction-level model plus directed literal expectations.
module tb_bus_mem_responder;
    localparam int N = 3;

`ifdef BUS_RESP_FETCH_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic        rw = 1'b0;
    logic        fi = 1'b0;
    logic        dt = 1'b0;

    logic [N-1:0] ack_w, err_w, oe_w, busy_w;
    logic [7:0]   dout_w [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        bus_mem_responder_if bus ();
        assign bus.a    = a;
        assign bus.d_in = d_in;
        assign bus.rw   = rw;
        assign bus.fi   = fi;
        assign bus.dt   = dt;
        bus_mem_responder #(
            .BASE        (16'hC000),
            .ADDR_W      (8),
            .WAIT_STATES (WS)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );
        assign ack_w[g]  = bus.ack;
        assign err_w[g]  = bus.err;
        assign oe_w[g]   = bus.d_oe;
        assign busy_w[g] = bus.busy;
        assign dout_w[g] = bus.d_out;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a pending transfer counts down wait cycles, then one ACK cycle,
    // then the responder is held off until the initiator drops DT.
    bit         m_pend [N];
    int         m_left [N];
    bit         m_ack  [N];
    bit         m_hold [N];
    int         l_off  [N];
    bit         l_rw   [N];
    bit         l_fi   [N];
    logic [7:0] l_d    [N];
    logic [7:0] m_ram  [N][256];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_left[i] = 0; m_ack[i] = 0; m_hold[i] = 0;
            l_off[i] = 0; l_rw[i] = 0; l_fi[i] = 0; l_d[i] = 8'h00;
            for (int j = 0; j < 256; j++) m_ram[i][j] = 8'h00;
        end
    end

    task automatic m_complete(input int i);
        m_pend[i] = 0;
        m_ack[i]  = 1;
        if (!l_rw[i] && !(GUARD && l_fi[i])) m_ram[i][l_off[i]] = l_d[i];
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_ack[i] = 0; m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) begin
                    m_ack[i]  = 0;
                    m_hold[i] = 1;
                end else if (m_hold[i]) begin
                    if (!dt) m_hold[i] = 0;
                end else if (m_pend[i]) begin
                    if (!dt) m_pend[i] = 0;
                    else begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) m_complete(i);
                    end
                end else if (dt && ((a >> 8) == 16'h00C0)) begin
                    l_off[i]  = a % 256;
                    l_rw[i]   = rw;
                    l_fi[i]   = fi;
                    l_d[i]    = d_in;
                    m_pend[i] = 1;
                    m_left[i] = ws_of(i);
                    if (m_left[i] == 0) m_complete(i);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit         e_oe;
        logic [7:0] e_do;
        for (int i = 0; i < N; i++) begin
            e_oe = m_ack[i] && l_rw[i] && !(GUARD && l_fi[i]);
            e_do = e_oe ? m_ram[i][l_off[i]] : 8'h00;
            chk($sformatf("ack[ws%0d]", ws_of(i)), ack_w[i], m_ack[i]);
            chk($sformatf("busy[ws%0d]", ws_of(i)), busy_w[i], m_pend[i] | m_ack[i] | m_hold[i]);
            chk($sformatf("err[ws%0d]", ws_of(i)), err_w[i], m_ack[i] && GUARD && l_fi[i]);
            chk($sformatf("d_oe[ws%0d]", ws_of(i)), oe_w[i], e_oe);
            chk($sformatf("d_out[ws%0d]", ws_of(i)), dout_w[i], e_do);
        end
    end

    // Per-transfer observations used by the literal expectations
    int         tcyc = 0;
    int         first_ack [N];
    int         ack_cnt   [N];
    int         oe_cnt    [N];
    int         err_cnt   [N];
    int         busy_seen [N];
    logic [7:0] rdata     [N];

    task automatic clear_stats();
        tcyc = 0;
        for (int i = 0; i < N; i++) begin
            first_ack[i] = 0; ack_cnt[i] = 0; oe_cnt[i] = 0;
            err_cnt[i] = 0; busy_seen[i] = 0; rdata[i] = 8'h00;
        end
    endtask

    always @(negedge clk) begin : monitor
        tcyc++;
        for (int i = 0; i < N; i++) begin
            if (ack_w[i]) begin
                ack_cnt[i]++;
                if (first_ack[i] == 0) first_ack[i] = tcyc;
                rdata[i] = dout_w[i];
            end
            if (oe_w[i]) oe_cnt[i]++;
            if (err_w[i]) err_cnt[i]++;
            if (busy_w[i]) busy_seen[i] = 1;
        end
    end

    // DT is sampled high on 'hold' edges, then low on 'gap' edges; stats start after the capture edge
    task automatic xfer(input logic [15:0] addr, input bit r, input bit f, input logic [7:0] data,
                        input int hold, input int gap);
        a = addr; rw = r; fi = f; d_in = data; dt = 1'b1;
        @(posedge clk); #1;
        clear_stats();
        for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
        end
        dt = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_ack[ws%0d]", ws_of(i)), ack_w[i], 0);
            chk($sformatf("rst_busy[ws%0d]", ws_of(i)), busy_w[i], 0);
            chk($sformatf("rst_oe[ws%0d]", ws_of(i)), oe_w[i], 0);
            chk($sformatf("rst_dout[ws%0d]", ws_of(i)), dout_w[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload locations whose old contents later tests depend on
        xfer(16'hC020, 0, 0, 8'h11, 6, 2);
        xfer(16'hC030, 0, 0, 8'h33, 6, 2);
        xfer(16'hC0FF, 0, 0, 8'h9C, 6, 2);

        // Write then read back; ACK lands WAIT_STATES+1 samples after capture
        xfer(16'hC010, 0, 0, 8'h5A, 6, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wr_lat[ws%0d]", ws_of(i)), first_ack[i], ws_of(i) + 1);
            chk($sformatf("wr_acks[ws%0d]", ws_of(i)), ack_cnt[i], 1);
            chk($sformatf("wr_oe[ws%0d]", ws_of(i)), oe_cnt[i], 0);
        end
        xfer(16'hC010, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rd_data[ws%0d]", ws_of(i)), rdata[i], 8'h5A);
            chk($sformatf("rd_oe_cycles[ws%0d]", ws_of(i)), oe_cnt[i], 1);
        end

        // Miss: nothing responds
        xfer(16'h1234, 1, 0, 8'h00, 10, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("miss_acks[ws%0d]", ws_of(i)), ack_cnt[i], 0);
            chk($sformatf("miss_busy[ws%0d]", ws_of(i)), busy_seen[i], 0);
            chk($sformatf("miss_oe[ws%0d]", ws_of(i)), oe_cnt[i], 0);
        end

        // DT dropped in the second wait cycle: only the 3-wait responder aborts
        xfer(16'hC020, 0, 0, 8'hFF, 2, 2);
        for (int i = 0; i < N; i++)
            chk($sformatf("abort_acks[ws%0d]", ws_of(i)), ack_cnt[i], (i == 2) ? 0 : 1);
        xfer(16'hC020, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++)
            chk($sformatf("abort_rd[ws%0d]", ws_of(i)), rdata[i], (i == 2) ? 8'h11 : 8'hFF);

        // Reset mid-transfer: zero-wait write already committed, others discarded
        a = 16'hC030; rw = 1'b0; fi = 1'b0; d_in = 8'h77; dt = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("arst_ack[ws%0d]", ws_of(i)), ack_w[i], 0);
            chk($sformatf("arst_busy[ws%0d]", ws_of(i)), busy_w[i], 0);
            chk($sformatf("arst_oe[ws%0d]", ws_of(i)), oe_w[i], 0);
            chk($sformatf("arst_err[ws%0d]", ws_of(i)), err_w[i], 0);
        end
        dt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(16'hC030, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++)
            chk($sformatf("arst_rd[ws%0d]", ws_of(i)), rdata[i], (i == 0) ? 8'h77 : 8'h33);

        // Held DT gives one ACK; a single low cycle re-arms
        xfer(16'hC010, 1, 0, 8'h00, 10, 1);
        for (int i = 0; i < N; i++)
            chk($sformatf("hold_acks[ws%0d]", ws_of(i)), ack_cnt[i], 1);
        xfer(16'hC010, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rearm_acks[ws%0d]", ws_of(i)), ack_cnt[i], 1);
            chk($sformatf("rearm_lat[ws%0d]", ws_of(i)), first_ack[i], ws_of(i) + 1);
        end

        // Top of window
        xfer(16'hC0FF, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("top_rd[ws%0d]", ws_of(i)), rdata[i], 8'h9C);
            chk($sformatf("top_lat[ws%0d]", ws_of(i)), first_ack[i], ws_of(i) + 1);
        end

        // Instruction fetch read and write
        xfer(16'hC010, 1, 1, 8'h00, 6, 2);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fetch_acks[ws%0d]", ws_of(i)), ack_cnt[i], 1);
            chk($sformatf("fetch_err[ws%0d]", ws_of(i)), err_cnt[i], GUARD ? 1 : 0);
            chk($sformatf("fetch_oe[ws%0d]", ws_of(i)), oe_cnt[i], GUARD ? 0 : 1);
            chk($sformatf("fetch_rd[ws%0d]", ws_of(i)), rdata[i], GUARD ? 8'h00 : 8'h5A);
        end
        xfer(16'hC010, 0, 1, 8'h00, 6, 2);
        xfer(16'hC010, 1, 0, 8'h00, 6, 2);
        for (int i = 0; i < N; i++)
            chk($sformatf("fetch_wr_rd[ws%0d]", ws_of(i)), rdata[i], GUARD ? 8'h5A : 8'h00);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
